// File: rtl/pwm_dac_pkg.sv
// rtl/pwm_dac_pkg.sv - shared FSM state type and default parameters for the PWM DAC
package pwm_dac_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int PWM_DAC_N_DEFAULT        = 12;
  localparam int PWM_DAC_PRESCALE_DEFAULT = 4;

endpackage

// File: rtl/pwm_period_counter.sv
// rtl/pwm_period_counter.sv - prescaler plus N-bit PWM period counter with boundary flag
module pwm_period_counter #(
  parameter int N        = 12,
  parameter int PRESCALE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  output logic [N-1:0] cnt,
  output logic         boundary
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;

  // Leaving run clears both counters so every restart begins on a boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
      cnt <= '0;
    end else if (!run) begin
      pre <= '0;
      cnt <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
      cnt <= cnt + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign boundary = run && (cnt == '0) && (pre == '0);

endmodule

// File: rtl/pwm_dac.sv
// rtl/pwm_dac.sv - PWM DAC top: sample handshake, staging/duty registers and run FSM
// Optional PWM_DAC_ZERO_ON_UNDERRUN_EN: silence (duty 0) on underrun instead of holding.
module pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter int N        = PWM_DAC_N_DEFAULT,
  parameter int PRESCALE = PWM_DAC_PRESCALE_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] sample_in,
  input  logic         sample_valid,
  output logic         sample_ready,
  output logic         pwm_out,
  output logic         period_start,
  output logic         underrun
);

  state_t       state, state_nxt;
  logic         run;
  logic         boundary;
  logic         xfer;
  logic         stage_full, stage_full_nxt;
  logic [N-1:0] cnt;
  logic [N-1:0] stage_q;
  logic [N-1:0] duty, duty_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // run is gated by ena so the clk that leaves S_RUN already behaves as idle.
  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    case (state)
      S_IDLE: if (ena) state_nxt = S_RUN;
      S_RUN: begin
        run = ena;
        if (!ena) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  pwm_period_counter #(
    .N        (N),
    .PRESCALE (PRESCALE)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .cnt      (cnt),
    .boundary (boundary)
  );

  assign xfer = sample_valid && sample_ready;

  always_comb begin
    stage_full_nxt = stage_full;
    duty_nxt       = duty;
    if (boundary && stage_full) begin
      stage_full_nxt = 1'b0;
      duty_nxt       = stage_q;
    end else begin
      if (xfer) stage_full_nxt = 1'b1;
`ifdef PWM_DAC_ZERO_ON_UNDERRUN_EN
      if (boundary) duty_nxt = '0;
`endif
    end
  end

  // Compare against duty_nxt so count 0 of a new period already uses the new duty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q      <= '0;
      stage_full   <= 1'b0;
      duty         <= '0;
      sample_ready <= 1'b0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      if (xfer) stage_q <= sample_in;
      stage_full   <= stage_full_nxt;
      duty         <= duty_nxt;
      sample_ready <= ~stage_full_nxt;
      pwm_out      <= run && (cnt < duty_nxt);
      period_start <= boundary;
      underrun     <= boundary && !stage_full;
    end
  end

endmodule

// File: tb/tb_pwm_dac.sv
// tb/tb_pwm_dac.sv - self-checking bench for pwm_dac (N=4, PRESCALE=1 and PRESCALE=3)
`timescale 1ns/1ps
module tb_pwm_dac;

  localparam int N = 4;
`ifdef PWM_DAC_ZERO_ON_UNDERRUN_EN
  localparam bit ZERO_ON_UR = 1'b1;
`else
  localparam bit ZERO_ON_UR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena = 1'b0;
  logic         sample_valid = 1'b0;
  logic [N-1:0] sample_in = '0;
  logic         sample_ready, pwm_out, period_start, underrun;

  logic         ena3 = 1'b0;
  logic         sv3 = 1'b0;
  logic [N-1:0] sin3 = '0;
  logic         sr3, pwm3, ps3, ur3;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int duty;
    int urun;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pwm_dac #(.N(N), .PRESCALE(1)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .underrun     (underrun)
  );

  pwm_dac #(.N(N), .PRESCALE(3)) u_dut3 (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena3),
    .sample_in    (sin3),
    .sample_valid (sv3),
    .sample_ready (sr3),
    .pwm_out      (pwm3),
    .period_start (ps3),
    .underrun     (ur3)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int hold_of(input int prev);
    return ZERO_ON_UR ? 0 : prev;
  endfunction

  task automatic sb_push(input int d, input int u);
    exp_t e;
    e.duty = d;
    e.urun = u;
    sb.push_back(e);
  endtask

  task automatic stage(input logic [N-1:0] v);
    int n = 0;
    while (!sample_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!sample_ready) check_eq("ready_timeout", sample_ready, 1);
    sample_in    = v;
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
  endtask

  // Called on the negedge where period_start is seen; ends on the next one.
  task automatic measure(output int highs, output int len);
    highs = 0;
    len   = 0;
    do begin
      if (pwm_out) highs++;
      len++;
      @(negedge clk);
    end while (!period_start && len < 400);
  endtask

  task automatic measure3(output int highs, output int len);
    highs = 0;
    len   = 0;
    do begin
      if (pwm3) highs++;
      len++;
      @(negedge clk);
    end while (!ps3 && len < 400);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, highs, len;

    #1 rst = 1'b0;
    #1;
    check_eq("rst_pwm", pwm_out, 0);
    check_eq("rst_ready", sample_ready, 0);
    check_eq("rst_pstart", period_start, 0);
    check_eq("rst_urun", underrun, 0);
    check_eq("rst_ready3", sr3, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check_eq("ready_at_release", sample_ready, 0);
    @(negedge clk);
    check_eq("ready_after_release", sample_ready, 1);

    fork
      begin : stim
        int m;
        stage(4'd5);  sb_push(5, 0);
        ena = 1'b1;
        stage(4'd15); sb_push(15, 0);
        stage(4'd0);  sb_push(0, 0);
        stage(4'd9);  sb_push(9, 0);
        sb_push(hold_of(9), 1);
        m = 0;
        @(negedge clk);
        while (!underrun && m < 200) begin
          @(negedge clk);
          m++;
        end
        check_eq("urun_seen", underrun, 1);
        // Land sample_valid exactly on the next boundary clk.
        repeat (15) @(negedge clk);
        check_eq("ready_on_boundary", sample_ready, 1);
        sb_push(hold_of(9), 1);
        sb_push(7, 0);
        sample_in    = 4'd7;
        sample_valid = 1'b1;
        @(posedge clk);
        #1 sample_valid = 1'b0;
      end
      begin : mon
        int m, h, l;
        exp_t e;
        m = 0;
        while (!period_start && m < 300) begin
          @(negedge clk);
          m++;
        end
        check_eq("first_pstart", period_start, 1);
        for (int k = 0; k < 7; k++) begin
          check_eq($sformatf("sb_has_p%0d", k), int'(sb.size() > 0), 1);
          if (sb.size() > 0) e = sb.pop_front();
          else begin e.duty = -1; e.urun = -1; end
          check_eq($sformatf("urun_p%0d", k), underrun, e.urun);
          measure(h, l);
          check_eq($sformatf("duty_p%0d", k), h, e.duty);
          check_eq($sformatf("len_p%0d", k), l, 16);
        end
      end
    join

    stage(4'd12);
    n = 0;
    @(negedge clk);
    while (!period_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("pwm_before_rst", pwm_out, 1);
    check_eq("ready_before_rst", sample_ready, 1);
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_pwm", pwm_out, 0);
    check_eq("async_rst_ready", sample_ready, 0);
    ena = 1'b0;
    @(negedge clk);
    check_eq("pwm_in_rst", pwm_out, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst2", sample_ready, 1);

    n = 0;
    while (!sr3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("p3_ready", sr3, 1);
    sin3 = 4'd8;
    sv3  = 1'b1;
    @(posedge clk);
    #1 sv3 = 1'b0;
    ena3 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ps3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("p3_start", ps3, 1);
    check_eq("p3_urun", ur3, 0);
    measure3(highs, len);
    check_eq("p3_len", len, 48);
    check_eq("p3_highs", highs, 24);
    repeat (5) @(negedge clk);
    check_eq("p3_high_mid", pwm3, 1);
    ena3 = 1'b0;
    @(negedge clk);
    check_eq("p3_off", pwm3, 0);
    repeat (3) @(negedge clk);
    ena3 = 1'b1;
    @(negedge clk);
    check_eq("p3_no_early_start", ps3, 0);
    @(negedge clk);
    check_eq("p3_restart", ps3, 1);
    check_eq("p3_restart_urun", ur3, 1);
    measure3(highs, len);
    check_eq("p3_len2", len, 48);
    check_eq("p3_highs2", highs, hold_of(8) * 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_dac.md
PWM_DAC -- requirements
Module: pwm_dac

Interface
- REQ-001 SHALL have parameter N, default 12, sample width in bits, legal range 2..16.
- REQ-002 SHALL have parameter PRESCALE, default 4, clk cycles per PWM count step, legal range >=1.
- REQ-003 SHALL have port clk  input  1  the single clock; all state is on its rising edge.
- REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
- REQ-005 SHALL have port ena  input  1  run enable.
- REQ-006 SHALL have port sample_in  input  N  unsigned sample, same format as the wave-select output.
- REQ-007 SHALL have port sample_valid  input  1  sample_in is offered this cycle.
- REQ-008 SHALL have port sample_ready  output  1  staging register is empty and will accept a sample.
- REQ-009 SHALL have port pwm_out  output  1  registered PWM bit driving the analog filter pin.
- REQ-010 SHALL have port period_start  output  1  one-cycle pulse on the first clk of each PWM period.
- REQ-011 SHALL have port underrun  output  1  one-cycle pulse when a period starts with no staged sample.

Function
- REQ-012 SHALL implement a two-state FSM: S_IDLE and S_RUN.
- REQ-013 S_IDLE -> S_RUN SHALL occur on the first clk with ena=1; S_RUN -> S_IDLE SHALL occur on the first clk with ena=0.
- REQ-014 In S_IDLE: pwm_out=0, prescaler=0, period counter cnt=0, no pulses; staging and duty registers SHALL hold their values.
- REQ-015 Handshake: a transfer SHALL occur when sample_valid && sample_ready, in any state; sample_ready SHALL be the registered inverse of the staging-full flag.
- REQ-016 In S_RUN the prescaler SHALL count 0..PRESCALE-1; cnt (N bits) SHALL advance by 1 each prescaler wrap and SHALL wrap 2^N-1 -> 0.
- REQ-017 Period boundary = clk where cnt==0 and prescaler==0 in S_RUN, including the first S_RUN clk; period_start SHALL pulse there.
- REQ-018 At a boundary with staging full: duty <= staging; staging SHALL be marked empty.
- REQ-019 At a boundary with staging empty: underrun SHALL pulse and duty SHALL be handled per REQ-027/REQ-028.
- REQ-020 A sample transferred on the boundary clk SHALL go to staging only; underrun SHALL still pulse.
- REQ-021 pwm_out SHALL be registered as (cnt < duty) in S_RUN; latency is one clk from cnt to pin.
- REQ-022 duty=0 SHALL give a constant low; duty=2^N-1 SHALL give high for all but one count per period.
- REQ-023 One PWM period SHALL last exactly PRESCALE*2^N clk.

Reset
- REQ-024 While rst=0: state=S_IDLE, cnt=0, prescaler=0, duty=0, staging empty, pwm_out=0, sample_ready=0, period_start=0, underrun=0.
- REQ-025 Reset assertion mid-period SHALL force those values immediately, without waiting for clk.
- REQ-026 sample_ready SHALL rise on the first clk after rst deasserts.

Configuration
- REQ-027 With PWM_DAC_ZERO_ON_UNDERRUN_EN defined, an underrun boundary SHALL load duty <= 0 (silence).
- REQ-028 Without PWM_DAC_ZERO_ON_UNDERRUN_EN, an underrun boundary SHALL keep the previous duty (sample hold).

Structure
- REQ-029 Package pwm_dac_pkg SHALL hold the state enum (S_IDLE, S_RUN) and the default N and PRESCALE constants.
- REQ-030 The prescaler/period counter SHALL be a sub-module pwm_period_counter, outputs cnt and boundary.
- REQ-031 The handshake, staging, duty and FSM logic SHALL live in pwm_dac.

Verification (N=4, PRESCALE=1 unless stated)
- REQ-032 Reset: drop rst mid-period with pwm_out=1 -> pwm_out=0 and sample_ready=0 with no clk edge; sample_ready=1 one clk after release.
- REQ-033 Duty: stage 5, ena=1 -> 16-clk periods, pwm_out high for 5 clk then low for 11, period_start every 16 clk.
- REQ-034 Extremes: stage 0 -> pwm_out never high; stage 15 -> high 15, low 1 per period.
- REQ-035 Underrun: stage 9 once, then offer nothing -> second boundary pulses underrun; duty=0 with the macro, duty=9 without.
- REQ-036 Boundary handshake: staging empty, sample_valid on the boundary clk with 7 -> underrun pulses and 7 appears at the next period.
- REQ-037 Enable and PRESCALE=3: drop ena mid-period -> pwm_out=0 next clk; re-enable -> immediate period_start; period = 48 clk.
